load_store_unit: RTL

- Initiator side of the data-memory interface: accepts one load/store per handshake from the memory pipeline stage and issues a word-aligned request to the data memory.
- Generates byte strobes and lane-replicated write data; waits for memory ready; returns sign- or zero-extended load data.
- Flags unsupported ops, misalignment and bus timeouts as errors.
- Sits between the execute/memory pipeline registers and the data memory; stalls the pipeline via req_ready.

---
 rtl/load_store_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator with byte strobes, load extension and timeout; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module load_store_unit #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    output logic                     resp_err_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    output logic [3:0]               mem_wstrb_o,
    input  logic                     mem_ready_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                   state_q, state_d;
    logic                     write_q;
    logic [2:0]               funct3_q;
    logic [1:0]               off_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, load_data;
    logic [3:0]               wstrb_q, wstrb_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d, unsupported, misaligned, capture;
    logic [7:0]               ld_byte;
    logic [15:0]              ld_half;

    assign unsupported = req_write_i ? (req_funct3_i[2] || req_funct3_i[1:0] == 2'b11)
                                     : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                        (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign wdata_d = !req_write_i ? '0 :
                     req_funct3_i[1:0] == 2'b00 ? {4{req_wdata_i[7:0]}} :
                     req_funct3_i[1:0] == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    assign wstrb_d = !req_write_i ? 4'b0000 :
                     req_funct3_i[1:0] == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
                     req_funct3_i[1:0] == 2'b01 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign ld_byte   = mem_rdata_i[{off_q, 3'b000} +: 8];
    assign ld_half   = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign load_data = funct3_q == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
                       funct3_q == 3'b100 ? {24'b0, ld_byte} :
                       funct3_q == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
                       funct3_q == 3'b101 ? {16'b0, ld_half} : mem_rdata_i;

    // Next-state: accept in IDLE, wait for ready or timeout in ACCESS, single response cycle
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (req_valid_i) begin
                capture = 1'b1;
                err_d   = unsupported || misaligned;
                rdata_d = '0;
                cnt_d   = '0;
                state_d = (unsupported || misaligned) ? RESP : ACCESS;
            end
            ACCESS: if (mem_ready_i) begin
                rdata_d = write_q ? '0 : load_data;
                state_d = RESP;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (capture) begin
                write_q  <= req_write_i;
                funct3_q <= req_funct3_i;
                off_q    <= req_addr_i[1:0];
                addr_q   <= {req_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
                wdata_q  <= wdata_d;
                wstrb_q  <= wstrb_d;
            end
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign resp_err_o   = resp_valid_o && err_q;
    assign resp_rdata_o = rdata_q;
    assign mem_req_o    = state_q == ACCESS;
    assign mem_we_o     = mem_req_o && write_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wstrb_o  = wstrb_q;
endmodule
